// File: rtl/stk_cli_pkg.sv
// rtl/stk_cli_pkg.sv - shared types and defaults for the stack client
package stk_cli_pkg;

    localparam int STK_W     = 64;
    localparam int STK_DEPTH = 4;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } stk_opcode_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } stk_cli_state_t;

    typedef struct packed {
        logic             rnw;
        logic [STK_W-1:0] dat;
    } stk_cli_cmd_t;

endpackage

// File: rtl/stk_cli_if.sv
// rtl/stk_cli_if.sv - slave command/response and stk cmd/ack/rsp signal bundle
interface stk_cli_if import stk_cli_pkg::*; #(parameter int W = STK_W);

    logic          i_slv_cmd_vld;
    logic          i_slv_cmd_rnw;
    logic [W-1:0]  i_slv_cmd_dat;
    logic          o_slv_rsp_vld;
    logic [W-1:0]  o_slv_rsp_dat;
    logic          o_stk_cmd_vld;
    stk_opcode_t   o_stk_cmd_opcode;
    logic [W-1:0]  o_stk_cmd_dat;
    logic          i_stk_cmd_ack;
    logic          i_stk_rsp_vld;
    logic [W-1:0]  i_stk_rsp_dat;

    // slave: the stack client itself
    modport slave (
        input  i_slv_cmd_vld, i_slv_cmd_rnw, i_slv_cmd_dat,
        input  i_stk_cmd_ack, i_stk_rsp_vld, i_stk_rsp_dat,
        output o_slv_rsp_vld, o_slv_rsp_dat,
        output o_stk_cmd_vld, o_stk_cmd_opcode, o_stk_cmd_dat
    );

    modport master (
        output i_slv_cmd_vld, i_slv_cmd_rnw, i_slv_cmd_dat,
        output i_stk_cmd_ack, i_stk_rsp_vld, i_stk_rsp_dat,
        input  o_slv_rsp_vld, o_slv_rsp_dat,
        input  o_stk_cmd_vld, o_stk_cmd_opcode, o_stk_cmd_dat
    );

endinterface

// File: rtl/stk_cli_cmd_fifo.sv
// rtl/stk_cli_cmd_fifo.sv - generic synchronous flop-array FIFO with full/empty/count
module stk_cli_cmd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

endmodule

// File: rtl/stk_cli.sv
// rtl/stk_cli.sv - stack client: buffers slave commands and issues stk push/pop one at a time
module stk_cli import stk_cli_pkg::*; #(
    parameter int W     = STK_W,
    parameter int DEPTH = STK_DEPTH
) (
    input  logic        clk,
    input  logic        arst_n,
    stk_cli_if.slave    bus,
    output logic        o_busy,
    output logic        o_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    stk_cli_state_t state;
    logic           cmd_vld;
    stk_opcode_t    cmd_op;
    logic [W-1:0]   cmd_dat;
    logic           rsp_vld;
    logic [W-1:0]   rsp_dat;
    logic           ovf;

    logic           fifo_wr;
    logic           fifo_rd;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W:0]     fifo_rd_data;
    logic [CW-1:0]  fifo_count;

    logic           push_done;
    logic           head_avail;
    logic           load;
    logic [W:0]     head;

    stk_cli_cmd_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr_en   (fifo_wr),
        .wr_data ({bus.i_slv_cmd_rnw, bus.i_slv_cmd_dat}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // An empty FIFO is bypassed so a slave command reaches the stk port one cycle later
    assign push_done  = (state == ISSUE) && bus.i_stk_cmd_ack && (cmd_op == PUSH);
    assign head_avail = !fifo_empty || bus.i_slv_cmd_vld;
    assign load       = head_avail && ((state == IDLE) || push_done);
    assign head       = fifo_empty ? {bus.i_slv_cmd_rnw, bus.i_slv_cmd_dat} : fifo_rd_data;
    assign fifo_rd    = load && !fifo_empty;
    assign fifo_wr    = bus.i_slv_cmd_vld && !(load && fifo_empty) && (!fifo_full || fifo_rd);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= IDLE;
            cmd_vld <= 1'b0;
            cmd_op  <= NOP;
            cmd_dat <= '0;
            rsp_vld <= 1'b0;
            rsp_dat <= '0;
        end else begin
            rsp_vld <= 1'b0;
            if (load) begin
                state   <= ISSUE;
                cmd_vld <= 1'b1;
                cmd_op  <= head[W] ? POP : PUSH;
                cmd_dat <= head[W-1:0];
            end else begin
                case (state)
                    ISSUE: begin
                        if (bus.i_stk_cmd_ack) begin
                            cmd_vld <= 1'b0;
                            if (cmd_op != POP) begin
                                state <= IDLE;
                            end else if (bus.i_stk_rsp_vld) begin
                                rsp_vld <= 1'b1;
                                rsp_dat <= bus.i_stk_rsp_dat;
                                state   <= IDLE;
                            end else begin
                                state <= WAIT_RSP;
                            end
                        end
                    end
                    WAIT_RSP: begin
                        if (bus.i_stk_rsp_vld) begin
                            rsp_vld <= 1'b1;
                            rsp_dat <= bus.i_stk_rsp_dat;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ovf <= 1'b0;
        end else if (bus.i_slv_cmd_vld && fifo_full && !fifo_rd) begin
            ovf <= 1'b1;
        end
    end

    assign bus.o_stk_cmd_vld    = cmd_vld;
    assign bus.o_stk_cmd_opcode = cmd_op;
    assign bus.o_stk_cmd_dat    = cmd_dat;
    assign bus.o_slv_rsp_vld    = rsp_vld;
    assign bus.o_slv_rsp_dat    = rsp_dat;
    assign o_busy               = (fifo_count != '0) || (state != IDLE);
    assign o_ovf                = ovf;

endmodule

// File: tb/tb_stk_cli.sv
// tb/tb_stk_cli.sv - scoreboard bench for stk_cli with a behavioural stack responder
module tb_stk_cli;
    import stk_cli_pkg::*;

    localparam int W     = 64;
    localparam int DEPTH = 4;

    typedef struct {
        stk_opcode_t  op;
        logic [W-1:0] dat;
    } exp_cmd_t;

    logic clk = 1'b0;
    logic arst_n;
    logic busy;
    logic ovf;

    always #5 clk = ~clk;

    stk_cli_if #(.W(W)) bus ();

    stk_cli #(.W(W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus),
        .o_busy (busy),
        .o_ovf  (ovf)
    );

    int checks   = 0;
    int errors   = 0;
    int ack_delay = 0;
    int rsp_delay = 0;
    bit ack_hold  = 1'b0;
    int hs_cnt    = 0;
    int rsp_seen  = 0;
    int sent_cnt  = 0;

    exp_cmd_t     exp_stk_q[$];
    logic [W-1:0] exp_rsp_q[$];
    logic [W-1:0] ref_stk[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: the stack effect of each accepted slave command is known at issue time
    task automatic send(input bit rnw, input logic [W-1:0] d, input bit accepted);
        bus.i_slv_cmd_vld = 1'b1;
        bus.i_slv_cmd_rnw = rnw;
        bus.i_slv_cmd_dat = d;
        if (accepted) begin
            sent_cnt++;
            exp_stk_q.push_back('{op: (rnw ? POP : PUSH), dat: d});
            if (rnw) begin
                exp_rsp_q.push_back(ref_stk.size() != 0 ? ref_stk.pop_back() : '0);
            end else begin
                ref_stk.push_back(d);
            end
        end
        @(negedge clk);
        bus.i_slv_cmd_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while ((busy || exp_stk_q.size() != 0 || exp_rsp_q.size() != 0) && n < 400);
        chk({name, "_drained"}, 64'(exp_stk_q.size() + exp_rsp_q.size()), 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    // Behavioural stk: LIFO with programmable ack and response latency
    initial begin
        int           wait_cnt = 0;
        int           rsp_wait = 0;
        logic [W-1:0] stk_mem[$];
        logic [W-1:0] rsp_hold = '0;
        bus.i_stk_cmd_ack = 1'b0;
        bus.i_stk_rsp_vld = 1'b0;
        bus.i_stk_rsp_dat = '0;
        forever begin
            @(negedge clk);
            bus.i_stk_cmd_ack = 1'b0;
            bus.i_stk_rsp_vld = 1'b0;
            if (!arst_n) begin
                stk_mem.delete();
                wait_cnt = 0;
                rsp_wait = 0;
            end else if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    bus.i_stk_rsp_vld = 1'b1;
                    bus.i_stk_rsp_dat = rsp_hold;
                end
            end else if (bus.o_stk_cmd_vld && !ack_hold) begin
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    bus.i_stk_cmd_ack = 1'b1;
                    if (bus.o_stk_cmd_opcode == PUSH) begin
                        stk_mem.push_back(bus.o_stk_cmd_dat);
                    end else begin
                        rsp_hold = (stk_mem.size() != 0) ? stk_mem.pop_back() : '0;
                        if (rsp_delay == 0) begin
                            bus.i_stk_rsp_vld = 1'b1;
                            bus.i_stk_rsp_dat = rsp_hold;
                        end else begin
                            rsp_wait = rsp_delay;
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a handshake or response
    initial begin
        exp_cmd_t e;
        forever begin
            @(negedge clk);
            #1;
            if (arst_n) begin
                if (bus.o_stk_cmd_vld && bus.i_stk_cmd_ack) begin
                    hs_cnt++;
                    chk("stk_cmd_expected", 64'(exp_stk_q.size() != 0), 1);
                    if (exp_stk_q.size() != 0) begin
                        e = exp_stk_q.pop_front();
                        chk("stk_opcode", 64'(bus.o_stk_cmd_opcode), 64'(e.op));
                        if (e.op == PUSH) begin
                            chk("stk_push_dat", bus.o_stk_cmd_dat, e.dat);
                        end
                    end
                end
                if (bus.o_slv_rsp_vld) begin
                    rsp_seen++;
                    chk("slv_rsp_expected", 64'(exp_rsp_q.size() != 0), 1);
                    if (exp_rsp_q.size() != 0) begin
                        chk("slv_rsp_dat", bus.o_slv_rsp_dat, exp_rsp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int           base;
        logic [W-1:0] held_dat;
        arst_n            = 1'b0;
        bus.i_slv_cmd_vld = 1'b0;
        bus.i_slv_cmd_rnw = 1'b0;
        bus.i_slv_cmd_dat = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_vld", bus.o_stk_cmd_vld, 0);
        chk("rst_opcode", 64'(bus.o_stk_cmd_opcode), 64'(NOP));
        chk("rst_rsp_vld", bus.o_slv_rsp_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        #3 arst_n = 1'b1;

        // single push, acked in the same cycle it is presented
        ack_delay = 0;
        rsp_delay = 0;
        base      = rsp_seen;
        @(negedge clk);
        send(1'b0, 64'hA5, 1'b1);
        #1;
        chk("t1_vld_cycle1", bus.o_stk_cmd_vld, 1);
        chk("t1_opcode", 64'(bus.o_stk_cmd_opcode), 64'(PUSH));
        chk("t1_dat", bus.o_stk_cmd_dat, 64'hA5);
        @(negedge clk);
        #1;
        chk("t1_vld_one_cycle", bus.o_stk_cmd_vld, 0);
        wait_idle("t1");
        chk("t1_no_slv_rsp", 64'(rsp_seen - base), 0);

        // push, push, pop, pop against a slow stk
        ack_delay = 2;
        rsp_delay = 3;
        base      = rsp_seen;
        @(negedge clk);
        send(1'b0, 64'h11, 1'b1);
        send(1'b0, 64'h22, 1'b1);
        send(1'b1, 64'h0, 1'b1);
        send(1'b1, 64'h0, 1'b1);
        wait_idle("t2");
        chk("t2_rsp_count", 64'(rsp_seen - base), 2);

        // pop with ack and response in the same cycle
        ack_delay = 0;
        rsp_delay = 0;
        @(negedge clk);
        send(1'b0, 64'hDEAD, 1'b1);
        wait_idle("t3_push");
        @(negedge clk);
        send(1'b1, 64'h0, 1'b1);
        #1;
        chk("t3_pop_vld", bus.o_stk_cmd_vld, 1);
        @(negedge clk);
        #1;
        chk("t3_rsp_vld", bus.o_slv_rsp_vld, 1);
        chk("t3_rsp_dat", bus.o_slv_rsp_dat, 64'hDEAD);
        chk("t3_no_wait_rsp", busy, 0);

        // overflow: six pushes while the stk refuses to ack
        ack_hold = 1'b1;
        base     = hs_cnt;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 64'(32'h100 + i), i < 5);
        end
        #1;
        chk("t4_ovf_set", ovf, 1);
        chk("t4_busy", busy, 1);
        ack_hold = 1'b0;
        wait_idle("t4");
        chk("t4_push_count", 64'(hs_cnt - base), 5);
        chk("t4_ovf_sticky", ovf, 1);

        // pop held off for ten cycles: command must stay stable
        ack_hold = 1'b1;
        @(negedge clk);
        send(1'b1, 64'h55, 1'b1);
        #1;
        held_dat = bus.o_stk_cmd_dat;
        for (int i = 0; i < 10; i++) begin
            chk("t5_stable", {bus.o_stk_cmd_vld, 2'(bus.o_stk_cmd_opcode), busy, bus.o_stk_cmd_dat == held_dat},
                {1'b1, 2'(POP), 1'b1, 1'b1});
            @(negedge clk);
            #1;
        end
        ack_hold = 1'b0;
        wait_idle("t5");

        // reset while waiting for a pop response with two commands queued
        ack_delay = 0;
        rsp_delay = 30;
        @(negedge clk);
        send(1'b1, 64'h0, 1'b1);
        send(1'b0, 64'h77, 1'b1);
        send(1'b0, 64'h78, 1'b1);
        #1;
        chk("t6_busy_before", busy, 1);
        #2 arst_n = 1'b0;
        #1;
        chk("t6_cmd_vld", bus.o_stk_cmd_vld, 0);
        chk("t6_opcode", 64'(bus.o_stk_cmd_opcode), 64'(NOP));
        chk("t6_cmd_dat", bus.o_stk_cmd_dat, 0);
        chk("t6_rsp", {bus.o_slv_rsp_vld, bus.o_slv_rsp_dat}, 0);
        chk("t6_busy_ovf", {busy, ovf}, 0);
        exp_stk_q.delete();
        exp_rsp_q.delete();
        ref_stk.delete();
        sent_cnt = hs_cnt;
        base     = rsp_seen;
        @(negedge clk);
        @(negedge clk);
        #3 arst_n = 1'b1;
        repeat (40) @(negedge clk);
        #2;
        chk("t6_no_rsp_after", 64'(rsp_seen - base), 0);
        chk("t6_idle_after", busy, 0);

        // randomized traffic, kept within FIFO capacity
        for (int i = 0; i < 150; i++) begin
            int n = 0;
            ack_delay = $urandom_range(0, 3);
            rsp_delay = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            while ((sent_cnt - hs_cnt) >= DEPTH && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                chk("rand_stall", 64'(sent_cnt - hs_cnt), 0);
            end
            send(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b1);
        end
        wait_idle("rand");
        chk("final_ovf", ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stk_cli.md
Name: stk_cli

Overview:
- Stack client: converts slave-interface commands into stack push/pop transactions on the stk command/response interface, and returns pop data on the slave response channel.
- Sits in q between the slave port and u_stk. It is the initiator end of the stk cmd/ack/rsp protocol.
- The slave channel has no backpressure, so commands are buffered in a small FIFO and issued one at a time.

Parameters:
- W, 64, data width of slave and stk data paths
- DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_slv_cmd_vld  in  1  slave command strobe
- i_slv_cmd_rnw  in  1  1=pop (read), 0=push (write)
- i_slv_cmd_dat  in  W  push data (ignored for pop)
- o_slv_rsp_vld  out  1  one-cycle pop response strobe
- o_slv_rsp_dat  out  W  popped data
- o_stk_cmd_vld  out  1  stk command valid
- o_stk_cmd_opcode  out  stk_opcode_t  PUSH or POP
- o_stk_cmd_dat  out  W  push data
- i_stk_cmd_ack  in  1  stk accepts command this cycle
- i_stk_rsp_vld  in  1  stk pop response valid
- i_stk_rsp_dat  in  W  stk pop data
- o_busy  out  1  FIFO non-empty or transaction in flight
- o_ovf  out  1  sticky: slave command dropped due to full FIFO

Behaviour:
- Reset (arst_n low, async): FSM=IDLE, FIFO empty, all outputs 0, opcode=NOP.
- One clock, clk; reset is asynchronous and active-low on arst_n.
- FIFO write:
  - On i_slv_cmd_vld with FIFO not full, push {rnw, dat}.
  - If full, drop the command, set o_ovf and hold it until reset.
  - A simultaneous FIFO pop in the same cycle frees a slot: write accepted when full && pop.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the registered cmd outputs; next=ISSUE. o_stk_cmd_vld rises the cycle after the FIFO write, giving minimum slave-cmd -> stk-cmd latency of 1 cycle.
  - ISSUE: o_stk_cmd_vld held high with stable opcode/dat until i_stk_cmd_ack.
    - Ack on PUSH -> IDLE. vld drops the next cycle unless a new head is loaded, which allows back-to-back issue.
    - Ack on POP with i_stk_rsp_vld in the same cycle -> capture the response; IDLE.
    - Ack on POP without rsp -> WAIT_RSP.
  - WAIT_RSP: o_stk_cmd_vld=0. On i_stk_rsp_vld, capture data -> IDLE.
- Slave response:
  - o_slv_rsp_vld is registered and pulses exactly one cycle, the cycle after the stk rsp is sampled; o_slv_rsp_dat holds the sampled value.
  - o_slv_rsp_dat holds its last value when vld is low.
- Push commands generate no slave response.
- i_stk_rsp_vld outside a pending pop (IDLE, ISSUE-PUSH) is ignored. This is an SVA-flagged protocol error.
- Ordering: strictly FIFO; at most one stk transaction outstanding.
- Empty-stack pop: stk returns data as defined by stk; the client forwards it unmodified.
- o_busy = FIFO non-empty OR state != IDLE (combinational from registers).
- Pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.
- Reset mid-transaction aborts everything: FIFO flushed, no response emitted.

Decomposition:
- q_pkg:
  - stk_opcode_t (2b enum: NOP=0, PUSH=1, POP=2)
  - stk_cli_state_t (IDLE, ISSUE, WAIT_RSP)
  - stk_cli_cmd_t struct {rnw, dat[W]}
- cfg_pkg: W and DEPTH defaults.
- Sub-module cmd_fifo (generic sync FIFO, flop array, full/empty/count) instantiated once; FSM and response register live in stk_cli.

Test Plan:
- Push 0xA5 (rnw=0), stk acks same cycle as vld -> o_stk_cmd_vld=1 for exactly one cycle at cycle 1, opcode=PUSH, dat=0xA5; no o_slv_rsp_vld.
- Push 0x11, push 0x22, pop, pop on consecutive cycles, stk model with ack delay 2 and rsp delay 3 -> stk sees PUSH 0x11, PUSH 0x22, POP, POP in order; slave rsp 0x22 then 0x11, each vld one cycle wide.
- Pop with ack and rsp in the same cycle (rsp_dat=0xDEAD) -> FSM skips WAIT_RSP; o_slv_rsp_vld=1 next cycle with 0xDEAD.
- 6 back-to-back pushes with ack held low, DEPTH=4 -> 1 in ISSUE, 4 in FIFO, 6th dropped, o_ovf=1; releasing ack yields exactly 5 PUSHes, o_ovf stays 1.
- Hold ack low for 10 cycles during a POP -> o_stk_cmd_vld, opcode and dat stable all 10 cycles; o_busy=1.
- Assert arst_n=0 in WAIT_RSP with 2 FIFO entries -> all outputs 0 immediately; after release, o_busy=0, the late stk rsp is ignored, and no slave rsp is produced.
